// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the alu and the alu arbiter
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } aluop_t;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational alu; overflow is signed and only meaningful for ADD/SUB
module alu
   import cpu_types_pkg::*;
(
   input  aluop_t     aluop,
   input  word_t      port_a,
   input  word_t      port_b,
   output word_t      result,
   output logic       negative,
   output logic       overflow,
   output logic       zero
);
   word_t sum, diff;
   assign sum  = port_a + port_b;
   assign diff = port_a - port_b;
   always_comb begin
      result = '0;
      case (aluop)
         ALU_ADD:  result = sum;
         ALU_SUB:  result = diff;
         ALU_AND:  result = port_a & port_b;
         ALU_OR:   result = port_a | port_b;
         ALU_XOR:  result = port_a ^ port_b;
         ALU_SLL:  result = port_a << port_b[4:0];
         ALU_SRL:  result = port_a >> port_b[4:0];
         ALU_SRA:  result = word_t'($signed(port_a) >>> port_b[4:0]);
         ALU_SLT:  result = {31'b0, $signed(port_a) < $signed(port_b)};
         ALU_SLTU: result = {31'b0, port_a < port_b};
         default:  result = '0;
      endcase
   end
   assign overflow = (aluop == ALU_ADD) ? (port_a[31] == port_b[31]) && (sum[31] != port_a[31]) :
                     (aluop == ALU_SUB) ? (port_a[31] != port_b[31]) && (diff[31] != port_a[31]) : 1'b0;
   assign negative = result[31];
   assign zero     = (result == '0);
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; ptr names the highest-priority requester
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic            en,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] id
);
   logic [ID_W-1:0] idx;
   logic            hit;
   // Scan from lowest priority to highest so the last hit is the winner
   always_comb begin
      id  = '0;
      hit = 1'b0;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr) + k) % NREQ);
         if (req[idx]) begin
            id  = idx;
            hit = 1'b1;
         end
      end
      gnt = (en && hit) ? NREQ'(1) << id : '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu between NREQ requesters,
// with registered operands and a per-requester held response.
module alu_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NREQ-1:0]     req,
   input  aluop_t [NREQ-1:0]   req_aluop,
   input  word_t  [NREQ-1:0]   req_port_a,
   input  word_t  [NREQ-1:0]   req_port_b,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output word_t               rsp_result,
   output logic                rsp_negative,
   output logic                rsp_overflow,
   output logic                rsp_zero,
   output logic                busy
);
   localparam int ID_W = $clog2(NREQ);
   arb_state_t      state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, win_id;
   aluop_t          op_q, op_d;
   word_t           a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
   logic            neg_q, neg_d, ovf_q, ovf_d, zero_q, zero_d;
   logic            alu_neg, alu_ovf, alu_zero, arb_en;
   logic [NREQ-1:0] vld_q, vld_d;
   // Reset also masks the combinational grant so outputs are quiet during reset
   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req (req),
      .en  (arb_en & ~n_rst),
      .ptr (ptr_q),
      .gnt (gnt),
      .id  (win_id)
   );
   alu u_alu (
      .aluop    (op_q),
      .port_a   (a_q),
      .port_b   (b_q),
      .result   (alu_res),
      .negative (alu_neg),
      .overflow (alu_ovf),
      .zero     (alu_zero)
   );
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      vld_d   = vld_q;
      arb_en  = 1'b0;
      case (state_q)
         IDLE: arb_en = 1'b1;
         EXEC: begin
            res_d   = alu_res;
            neg_d   = alu_neg;
            ovf_d   = alu_ovf;
            zero_d  = alu_zero;
            vld_d   = NREQ'(1) << id_q;
            state_d = RESP;
         end
         RESP: if (rsp_ready[id_q]) begin
            vld_d   = '0;
            arb_en  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (|gnt) begin
         id_d    = win_id;
         op_d    = req_aluop[win_id];
         a_d     = req_port_a[win_id];
         b_d     = req_port_b[win_id];
         ptr_d   = ID_W'((int'(win_id) + 1) % NREQ);
         state_d = EXEC;
      end
   end
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         op_q    <= ALU_ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         vld_q   <= vld_d;
      end
   end
   assign rsp_valid    = vld_q;
   assign rsp_result   = res_q;
   assign rsp_negative = neg_q;
   assign rsp_overflow = ovf_q;
   assign rsp_zero     = zero_q;
   assign busy         = (state_q != IDLE);
endmodule
